// File: rtl/sram_access_controller_if.sv
// CPU-side bus bundle for the SRAM access controller; the controller takes the slave modport.
// DMA signals exist only when SRAM_ACCESS_DMA_PORT_EN is defined.
interface sram_access_controller_if;
    logic        SRamSelect_H;
    logic        AS_L;
    logic        UDS_L;
    logic        LDS_L;
    logic        RW;
    logic [16:0] Address;
    logic [14:0] SRam_Addr;
    logic [3:0]  Block_CE_L;
    logic        SRam_OE_L;
    logic        SRam_WE_L;
    logic        SRam_UB_L;
    logic        SRam_LB_L;
    logic        Dtack_L;
    logic        Busy_H;
`ifdef SRAM_ACCESS_DMA_PORT_EN
    logic        Dma_Req_H;
    logic [16:0] Dma_Addr;
    logic        Dma_RW;
    logic        Dma_Gnt_H;
    logic        Dma_Ack_H;
`endif

    modport master (
`ifdef SRAM_ACCESS_DMA_PORT_EN
        output Dma_Req_H, Dma_Addr, Dma_RW,
        input  Dma_Gnt_H, Dma_Ack_H,
`endif
        output SRamSelect_H, AS_L, UDS_L, LDS_L, RW, Address,
        input  SRam_Addr, Block_CE_L, SRam_OE_L, SRam_WE_L, SRam_UB_L, SRam_LB_L,
        input  Dtack_L, Busy_H
    );

    modport slave (
`ifdef SRAM_ACCESS_DMA_PORT_EN
        input  Dma_Req_H, Dma_Addr, Dma_RW,
        output Dma_Gnt_H, Dma_Ack_H,
`endif
        input  SRamSelect_H, AS_L, UDS_L, LDS_L, RW, Address,
        output SRam_Addr, Block_CE_L, SRam_OE_L, SRam_WE_L, SRam_UB_L, SRam_LB_L,
        output Dtack_L, Busy_H
    );
endinterface

// File: rtl/sram_access_controller.sv
// 68k bus-cycle sequencer for the 256 KB SRAM (four 64 KB blocks), all outputs registered.
// Optional DMA port with round-robin arbitration: define SRAM_ACCESS_DMA_PORT_EN.
module sram_access_controller #(
    parameter int WAIT_STATES    = 2,
    parameter int RECOVER_CYCLES = 1
) (
    input logic                     Clock,
    input logic                     Reset_H,
    sram_access_controller_if.slave bus
);
    typedef enum logic [2:0] {IDLE, SETUP, ACCESS, ACK, RECOVER} state_t;

    localparam logic [3:0] WAIT_LD = 4'(WAIT_STATES);
    localparam logic [3:0] REC_LD  = 4'(RECOVER_CYCLES);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [16:0] addr_q, addr_d;
    logic        rw_q, rw_d, uds_q, uds_d, lds_q, lds_d, dma_q, dma_d;
    logic [3:0]  ce_q, ce_d;
    logic        oe_q, oe_d, we_q, we_d, ub_q, ub_d, lb_q, lb_d;
    logic        dtack_q, dtack_d, busy_q, busy_d;
    logic        cpu_req, strobing;
`ifdef SRAM_ACCESS_DMA_PORT_EN
    logic        prio_q, prio_d, gnt_q, gnt_d, dack_q, dack_d;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        rw_d    = rw_q;
        uds_d   = uds_q;
        lds_d   = lds_q;
        dma_d   = dma_q;
`ifdef SRAM_ACCESS_DMA_PORT_EN
        prio_d  = prio_q;
`endif
        cpu_req = !bus.AS_L && bus.SRamSelect_H && (!bus.UDS_L || !bus.LDS_L);

        case (state_q)
            IDLE: begin
                if (cpu_req) begin
                    state_d = SETUP;
                    addr_d  = bus.Address;
                    rw_d    = bus.RW;
                    uds_d   = bus.UDS_L;
                    lds_d   = bus.LDS_L;
                    dma_d   = 1'b0;
                end
`ifdef SRAM_ACCESS_DMA_PORT_EN
                // prio_q set means DMA wins the next simultaneous request
                if (bus.Dma_Req_H && (!cpu_req || prio_q)) begin
                    state_d = SETUP;
                    addr_d  = bus.Dma_Addr;
                    rw_d    = bus.Dma_RW;
                    uds_d   = 1'b0;
                    lds_d   = 1'b0;
                    dma_d   = 1'b1;
                end
                if (cpu_req && bus.Dma_Req_H) prio_d = !prio_q;
`endif
            end
            SETUP: begin
                if (bus.AS_L && !dma_q) begin
                    state_d = RECOVER;
                    cnt_d   = REC_LD;
                end else begin
                    state_d = ACCESS;
                    cnt_d   = WAIT_LD;
                end
            end
            ACCESS: begin
                if (bus.AS_L && !dma_q) begin
                    state_d = RECOVER;
                    cnt_d   = REC_LD;
                end else if (cnt_q <= 4'd1) begin
                    state_d = ACK;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ACK: begin
                if (bus.AS_L || dma_q) begin
                    state_d = RECOVER;
                    cnt_d   = REC_LD;
                end
            end
            RECOVER: begin
                if (cnt_q <= 4'd1) state_d = IDLE;
                else               cnt_d   = cnt_q - 4'd1;
            end
            default: state_d = IDLE;
        endcase

        // Outputs are a function of the state being entered, so they change with it
        strobing = (state_d == SETUP) || (state_d == ACCESS) || (state_d == ACK);
        ce_d     = strobing ? ~(4'b0001 << addr_d[16:15]) : 4'hF;
        oe_d     = !(strobing && rw_d);
        we_d     = !((state_d == ACCESS) && !rw_d);
        ub_d     = strobing ? uds_d : 1'b1;
        lb_d     = strobing ? lds_d : 1'b1;
        dtack_d  = !((state_d == ACK) && !dma_d);
        busy_d   = (state_d != IDLE);
`ifdef SRAM_ACCESS_DMA_PORT_EN
        gnt_d    = strobing && dma_d;
        dack_d   = (state_d == ACK) && dma_d;
`endif
    end

    always_ff @(posedge Clock) begin
        rw_q  <= rw_d;
        uds_q <= uds_d;
        lds_q <= lds_d;
        if (Reset_H) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= 17'd0;
            dma_q   <= 1'b0;
            ce_q    <= 4'hF;
            oe_q    <= 1'b1;
            we_q    <= 1'b1;
            ub_q    <= 1'b1;
            lb_q    <= 1'b1;
            dtack_q <= 1'b1;
            busy_q  <= 1'b0;
`ifdef SRAM_ACCESS_DMA_PORT_EN
            prio_q  <= 1'b0;
            gnt_q   <= 1'b0;
            dack_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            dma_q   <= dma_d;
            ce_q    <= ce_d;
            oe_q    <= oe_d;
            we_q    <= we_d;
            ub_q    <= ub_d;
            lb_q    <= lb_d;
            dtack_q <= dtack_d;
            busy_q  <= busy_d;
`ifdef SRAM_ACCESS_DMA_PORT_EN
            prio_q  <= prio_d;
            gnt_q   <= gnt_d;
            dack_q  <= dack_d;
`endif
        end
    end

    assign bus.SRam_Addr  = addr_q[14:0];
    assign bus.Block_CE_L = ce_q;
    assign bus.SRam_OE_L  = oe_q;
    assign bus.SRam_WE_L  = we_q;
    assign bus.SRam_UB_L  = ub_q;
    assign bus.SRam_LB_L  = lb_q;
    assign bus.Dtack_L    = dtack_q;
    assign bus.Busy_H     = busy_q;
`ifdef SRAM_ACCESS_DMA_PORT_EN
    assign bus.Dma_Gnt_H  = gnt_q;
    assign bus.Dma_Ack_H  = dack_q;
`endif
endmodule

// File: tb/tb_sram_access_controller.sv
// Bench for sram_access_controller: dut0 (2 wait states, 1 recovery) and dut1 (0 wait states, 3 recovery).
// Expected strobes come from a per-transaction phase timeline built from the bus-cycle rules.
module tb_sram_access_controller;
    localparam int PS = 0, PA = 1, PK = 2, PR = 3, PI = 4;
    localparam logic [9:0] IDLE_VEC = 10'b1111_1111_10;

    logic Clock = 1'b0;
    logic Reset_H;
    int   checks = 0;
    int   errors = 0;
    logic [16:0] n_addr;
    logic        n_rw, n_uds, n_lds;

    always #5 Clock = ~Clock;

    sram_access_controller_if b0();
    sram_access_controller_if b1();

    sram_access_controller #(.WAIT_STATES(2), .RECOVER_CYCLES(1)) dut0 (
        .Clock(Clock), .Reset_H(Reset_H), .bus(b0.slave));
    sram_access_controller #(.WAIT_STATES(0), .RECOVER_CYCLES(3)) dut1 (
        .Clock(Clock), .Reset_H(Reset_H), .bus(b1.slave));

    function automatic int acc_len(input int d);
        return (d == 0) ? 2 : 1;
    endfunction

    function automatic int rec_len(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    // {CE[3:0], OE, WE, UB, LB, DTACK, BUSY}
    function automatic logic [9:0] exp_vec(input int ph, input logic [16:0] a,
                                           input logic rw, input logic uds, input logic lds);
        logic [3:0] tab [4];
        logic       on;
        tab = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        on  = (ph == PS) || (ph == PA) || (ph == PK);
        return {on ? tab[a[16:15]] : 4'hF, !(on && rw), !((ph == PA) && !rw),
                on ? uds : 1'b1, on ? lds : 1'b1, !(ph == PK), (ph != PI)};
    endfunction

    function automatic logic [9:0] obs_vec(input int d);
        if (d == 0)
            return {b0.Block_CE_L, b0.SRam_OE_L, b0.SRam_WE_L, b0.SRam_UB_L, b0.SRam_LB_L,
                    b0.Dtack_L, b0.Busy_H};
        return {b1.Block_CE_L, b1.SRam_OE_L, b1.SRam_WE_L, b1.SRam_UB_L, b1.SRam_LB_L,
                b1.Dtack_L, b1.Busy_H};
    endfunction

    function automatic logic [14:0] obs_addr(input int d);
        return (d == 0) ? b0.SRam_Addr : b1.SRam_Addr;
    endfunction

    task automatic chk(input string tag, input int idx, input logic [31:0] o, input logic [31:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s[%0d] observed=%0h expected=%0h", tag, idx, o, e);
        end
    endtask

    task automatic drive(input int d, input logic as_l, input logic sel, input logic uds,
                         input logic lds, input logic rw, input logic [16:0] a);
        if (d == 0) begin
            b0.AS_L = as_l; b0.SRamSelect_H = sel; b0.UDS_L = uds; b0.LDS_L = lds;
            b0.RW = rw; b0.Address = a;
        end else begin
            b1.AS_L = as_l; b1.SRamSelect_H = sel; b1.UDS_L = uds; b1.LDS_L = lds;
            b1.RW = rw; b1.Address = a;
        end
    endtask

    // One CPU cycle; abort_j >= 0 releases AS_L after the SETUP (0) or j-th ACCESS cycle.
    // nxt_en re-asserts the n_* request during the first RECOVER cycle.
    task automatic run_cpu(input int d, input logic [16:0] a, input logic rw, input logic uds,
                           input logic lds, input int hold, input int abort_j,
                           input bit drop_sel, input bit pre, input bit nxt_en);
        int ph[$];
        int rel;
        if (!pre) drive(d, 1'b0, 1'b1, uds, lds, rw, a);
        ph.push_back(PS);
        if (abort_j >= 0) begin
            repeat (abort_j) ph.push_back(PA);
        end else begin
            repeat (acc_len(d)) ph.push_back(PA);
            repeat (hold + 1) ph.push_back(PK);
        end
        rel = ph.size() - 1;
        repeat (rec_len(d)) ph.push_back(PR);
        ph.push_back(PI);
        for (int i = 0; i < ph.size(); i++) begin
            @(posedge Clock);
            @(negedge Clock);
            chk("strobes", i, 32'(obs_vec(d)), 32'(exp_vec(ph[i], a, rw, uds, lds)));
            if (ph[i] == PS || ph[i] == PI) chk("sram_addr", i, 32'(obs_addr(d)), 32'(a[14:0]));
            if (i == 0 && drop_sel) drive(d, 1'b0, 1'b0, uds, lds, rw, a);
            if (i == rel) drive(d, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, a);
            if (i == rel + 1 && nxt_en) drive(d, 1'b0, 1'b1, n_uds, n_lds, n_rw, n_addr);
        end
    endtask

    initial begin
        logic [16:0] ra;
        int          rd, rsel, rab;
        Reset_H = 1'b1;
        drive(0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 17'h0);
        drive(1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 17'h0);
`ifdef SRAM_ACCESS_DMA_PORT_EN
        b0.Dma_Req_H = 1'b0; b0.Dma_Addr = 17'h0; b0.Dma_RW = 1'b1;
        b1.Dma_Req_H = 1'b0; b1.Dma_Addr = 17'h0; b1.Dma_RW = 1'b1;
`endif
        repeat (2) @(posedge Clock);
        @(negedge Clock);
        chk("reset_vec0", 0, 32'(obs_vec(0)), 32'(IDLE_VEC));
        chk("reset_vec1", 0, 32'(obs_vec(1)), 32'(IDLE_VEC));
        chk("reset_addr0", 0, 32'(obs_addr(0)), 32'h0);
        Reset_H = 1'b0;

        // Reset landing in the middle of a write access
        drive(0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 17'h08000);
        @(posedge Clock); @(negedge Clock);
        chk("rst_setup", 0, 32'(obs_vec(0)), 32'(exp_vec(PS, 17'h08000, 1'b0, 1'b0, 1'b0)));
        @(posedge Clock); @(negedge Clock);
        chk("rst_access", 0, 32'(obs_vec(0)), 32'(exp_vec(PA, 17'h08000, 1'b0, 1'b0, 1'b0)));
        Reset_H = 1'b1;
        drive(0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 17'h08000);
        @(posedge Clock); @(negedge Clock);
        chk("rst_mid_vec", 0, 32'(obs_vec(0)), 32'(IDLE_VEC));
        chk("rst_mid_addr", 0, 32'(obs_addr(0)), 32'h0);
        Reset_H = 1'b0;

        run_cpu(0, 17'h18004, 1'b1, 1'b0, 1'b0, 1, -1, 1'b0, 1'b0, 1'b0);
        run_cpu(1, 17'h00010, 1'b0, 1'b1, 1'b0, 0, -1, 1'b0, 1'b0, 1'b0);
        run_cpu(0, 17'h0A55A, 1'b1, 1'b0, 1'b0, 0, 1, 1'b0, 1'b0, 1'b0);
        run_cpu(0, 17'h0A55A, 1'b1, 1'b0, 1'b0, 0, -1, 1'b0, 1'b0, 1'b0);
        run_cpu(1, 17'h1FFFF, 1'b1, 1'b0, 1'b1, 2, -1, 1'b1, 1'b0, 1'b0);

        // Back-to-back: second request asserted while still recovering
        n_addr = 17'h12340; n_rw = 1'b0; n_uds = 1'b0; n_lds = 1'b0;
        run_cpu(0, 17'h04444, 1'b1, 1'b0, 1'b0, 0, -1, 1'b0, 1'b0, 1'b1);
        run_cpu(0, n_addr, n_rw, n_uds, n_lds, 0, -1, 1'b0, 1'b1, 1'b0);
        n_addr = 17'h0C001; n_rw = 1'b1; n_uds = 1'b1; n_lds = 1'b0;
        run_cpu(1, 17'h1C003, 1'b0, 1'b0, 1'b1, 0, -1, 1'b0, 1'b0, 1'b1);
        run_cpu(1, n_addr, n_rw, n_uds, n_lds, 1, -1, 1'b0, 1'b1, 1'b0);

        // Address-only phase and deselected strobe must not start a cycle
        drive(0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 17'h00100);
        for (int i = 0; i < 3; i++) begin
            @(posedge Clock); @(negedge Clock);
            chk("addr_only", i, 32'(obs_vec(0)), 32'(IDLE_VEC));
        end
        drive(0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 17'h00100);
        @(posedge Clock); @(negedge Clock);
        chk("not_selected", 0, 32'(obs_vec(0)), 32'(IDLE_VEC));
        drive(0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 17'h00100);

        for (int n = 0; n < 24; n++) begin
            rd   = $urandom_range(0, 1);
            ra   = 17'($urandom);
            rsel = $urandom_range(0, 2);
            rab  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, acc_len(rd)) : -1;
            run_cpu(rd, ra, 1'($urandom_range(0, 1)), (rsel == 1), (rsel == 2),
                    $urandom_range(0, 2), rab, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
        end

`ifdef SRAM_ACCESS_DMA_PORT_EN
        begin
            int dph[$];
            dph = '{PS, PA, PA, PK, PR, PI};
            b0.Dma_Req_H = 1'b1; b0.Dma_Addr = 17'h0A123; b0.Dma_RW = 1'b0;
            n_addr = 17'h14000; n_rw = 1'b1; n_uds = 1'b0; n_lds = 1'b0;
            drive(0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 17'h02345);
            run_cpu(0, 17'h02345, 1'b1, 1'b0, 1'b0, 0, -1, 1'b0, 1'b1, 1'b1);
            for (int i = 0; i < dph.size(); i++) begin
                @(posedge Clock); @(negedge Clock);
                chk("dma_strobes", i, 32'(obs_vec(0)),
                    32'(exp_vec(dph[i], 17'h0A123, 1'b0, 1'b0, 1'b0) | ((dph[i] == PK) ? 10'h002 : 10'h000)));
                chk("dma_gnt", i, 32'(b0.Dma_Gnt_H), 32'(dph[i] <= PK));
                chk("dma_ack", i, 32'(b0.Dma_Ack_H), 32'(dph[i] == PK));
                if (dph[i] == PS) chk("dma_addr", i, 32'(obs_addr(0)), 32'h2123);
                if (dph[i] == PK) b0.Dma_Req_H = 1'b0;
            end
            run_cpu(0, n_addr, n_rw, n_uds, n_lds, 0, -1, 1'b0, 1'b1, 1'b0);
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/sram_access_controller.md
Name: sram_access_controller

Overview:
- Sequences every 68k bus cycle targeting the 256 KB SRAM: decodes the four 64 KB block chip-enables, drives OE/WE/byte strobes with a programmable wait-state count, and generates DTACK back to the CPU.
- Sits between the top-level address decoder (SRamSelect_H) and the four SRAM block devices.
- Clocked single-domain FSM with an access counter and address/strobe latches.

Parameters:
- WAIT_STATES, 2, clock cycles spent in ACCESS before acknowledge (legal 0..15; 0 means ACCESS lasts 1 cycle).
- RECOVER_CYCLES, 1, idle cycles after each access, with all strobes high, before a new access may start (legal 1..3).

Ports:
- Clock  in  1  system clock; all logic is rising-edge.
- Reset_H  in  1  synchronous, active-high reset.
- SRamSelect_H  in  1  top-level decode: the CPU address is in SRAM space.
- AS_L  in  1  68k address strobe.
- UDS_L  in  1  68k upper data strobe.
- LDS_L  in  1  68k lower data strobe.
- RW  in  1  68k R/W: 1 = read, 0 = write.
- Address  in  17  CPU word address (lower 17 lines).
- SRam_Addr  out  15  word address within the selected block (latched Address[14:0]).
- Block_CE_L  out  4  per-block chip enable; bit n is block n, decoded from latched Address[16:15].
- SRam_OE_L  out  1  SRAM output enable.
- SRam_WE_L  out  1  SRAM write enable.
- SRam_UB_L  out  1  upper byte enable.
- SRam_LB_L  out  1  lower byte enable.
- Dtack_L  out  1  data transfer acknowledge to the 68k.
- Busy_H  out  1  high in any state other than IDLE.

Behaviour:
- Reset (Reset_H sampled high on a rising edge, including mid-access):
  - State goes to IDLE and the counter clears.
  - Block_CE_L = 4'hF; SRam_OE_L, SRam_WE_L, SRam_UB_L, SRam_LB_L and Dtack_L = 1.
  - SRam_Addr = 0; Busy_H = 0.
- All outputs are registered. States: IDLE, SETUP, ACCESS, ACK, RECOVER.
- IDLE:
  - Start condition: AS_L=0, SRamSelect_H=1 and (UDS_L=0 or LDS_L=0).
  - On start, latch Address, RW, UDS_L and LDS_L, then go to SETUP.
  - Latched values are held until the next IDLE start. Inputs are not re-sampled mid-cycle.
- SETUP (1 cycle):
  - Assert the decoded Block_CE_L bit, SRam_UB_L = latched UDS_L, SRam_LB_L = latched LDS_L.
  - SRam_OE_L = 0 if read. WE stays high.
  - Load counter with WAIT_STATES. Go to ACCESS.
- ACCESS:
  - Hold CE, byte enables and OE. If write, SRam_WE_L = 0.
  - Counter decrements each cycle; go to ACK when counter == 0. ACCESS therefore lasts max(WAIT_STATES,1) cycles.
- ACK:
  - Dtack_L = 0. For writes, SRam_WE_L returns to 1 on ACK entry while CE and byte enables stay asserted (data hold).
  - Read keeps OE and CE asserted.
  - Remain in ACK while AS_L=0. When AS_L is sampled 1, deassert Dtack_L, CE, OE and byte enables, then go to RECOVER.
- RECOVER: all strobes high; lasts RECOVER_CYCLES cycles, then IDLE.
- Start-to-DTACK latency = 2 + max(WAIT_STATES,1) cycles.
- Boundary conditions:
  - AS_L rising during SETUP/ACCESS (aborted cycle): go directly to RECOVER with all strobes high; no DTACK.
  - SRamSelect_H dropping after start: ignored.
  - A new AS_L falling edge during RECOVER: not accepted until IDLE. It is served on the first IDLE cycle if still asserted.
  - Both UDS_L and LDS_L high while AS_L=0: no start (address-only phase); remain in IDLE.
  - Exactly one Block_CE_L bit is low in SETUP/ACCESS/ACK; address 17'h1FFFF maps to block 3, SRam_Addr 15'h7FFF.

Optional Feature:
- Macro SRAM_ACCESS_DMA_PORT_EN.
- When defined:
  - Adds ports Dma_Req_H in 1, Dma_Addr in 17, Dma_RW in 1, Dma_Gnt_H out 1, Dma_Ack_H out 1.
  - DMA requests are sampled in IDLE. If both CPU and DMA request in the same cycle, grant alternates round-robin (reset favours CPU). Otherwise the sole requester wins.
  - Dma_Gnt_H is high SETUP through ACK of a DMA cycle.
  - DMA cycles are always word accesses (UB/LB both low), use the same SETUP/ACCESS timing, and leave Dtack_L high.
  - The DMA ACK state lasts 1 cycle with Dma_Ack_H = 1, then RECOVER.
  - A pending CPU cycle waits; its DTACK is simply delayed.
- When undefined: these ports do not exist and only the CPU path is built.

Test Plan:
- Reset mid-ACCESS (WAIT_STATES=2, write to 17'h08000) -> next cycle IDLE, Block_CE_L=4'hF, SRam_WE_L=1, Dtack_L=1, Busy_H=0.
- CPU word read at 17'h18004 with WAIT_STATES=2 -> Block_CE_L=4'b0111... (block 3 low: 4'b0111 with bit3=0), SRam_Addr=15'h0004, OE low from SETUP, Dtack_L low 4 cycles after start, released one cycle after AS_L high.
- Byte write (UDS_L=1, LDS_L=0) to 17'h00010, WAIT_STATES=0 -> SRam_LB_L=0, SRam_UB_L=1, WE low exactly 1 cycle, WE high in ACK while CE0 still low, DTACK at cycle 3.
- AS_L deasserted during ACCESS -> no DTACK, all strobes high next cycle, RECOVER for RECOVER_CYCLES, then a new read is served normally.
- Back-to-back CPU cycles with AS_L re-asserted in RECOVER -> second SETUP starts on the first cycle after IDLE, never during RECOVER.
- (SRAM_ACCESS_DMA_PORT_EN) CPU and DMA request together twice in a row -> CPU granted first, DMA second; Dma_Ack_H is a single-cycle pulse and Dtack_L stays high during the DMA cycle.
